// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Shared constants for the sequential multiply/divide engine:
//   - default operand width
//   - FSM state encoding (IDLE/RUN/FIX/DONE)
//   - operation select codes, matching the MDCtrl input
// ----------------------------------------------------------------------------
package md_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_seq_if.sv
// ----------------------------------------------------------------------------
// mult_div_seq_if
// Request/result bundle between the main control unit and mult_div_seq.
//   start   : one-cycle request (control -> engine)
//   MDCtrl  : 0 = MULT, 1 = DIV, sampled with start
//   a, b    : signed operands (rs, rt)
//   hi, lo  : MULT product high/low, or DIV remainder/quotient
//   busy    : engine is working on an accepted request
//   done    : one-cycle completion pulse
//   div0    : one-cycle divide-by-zero pulse, coincident with done
// Modports: master = control unit side, slave = engine side.
// ----------------------------------------------------------------------------
interface mult_div_seq_if #(
    parameter int WIDTH = md_pkg::MD_WIDTH
);

    logic             start;
    logic             MDCtrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output start, MDCtrl, a, b,
        input  hi, lo, busy, done, div0
    );

    modport slave (
        input  start, MDCtrl, a, b,
        output hi, lo, busy, done, div0
    );

endinterface

// File: rtl/md_step.sv
// ----------------------------------------------------------------------------
// md_step
// One combinational iteration of the unsigned multiply or divide loop.
//   i_op   : MD_MULT or MD_DIV
//   i_acc  : MULT: {partial product high, remaining multiplier bits}
//            DIV : low half holds dividend bits shifting out / quotient
//                  bits shifting in; high half passes through
//   i_rem  : DIV partial remainder (unused by MULT, passed through)
//   i_opnd : MULT multiplicand magnitude, or DIV divisor magnitude
//   o_acc  : accumulator after this iteration
//   o_rem  : remainder after this iteration
// ----------------------------------------------------------------------------
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               i_op,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_rem,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_rem
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Shift-add: the carry out of the high half becomes the new MSB once the
    // accumulator shifts right, so no product bit is lost.
    assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                 + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});

    // Restoring divide: the trial remainder needs WIDTH+1 bits because the
    // shifted remainder can reach 2*divisor-1. A kept remainder is always
    // below the divisor, so WIDTH bits are enough to store it.
    assign w_shift = {i_rem, i_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_opnd};

    always_comb begin
        o_acc = i_acc;
        o_rem = i_rem;
        if (i_op == MD_MULT) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], ~w_diff[WIDTH]};
            o_rem = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// ----------------------------------------------------------------------------
// mult_div_seq
// Iterative signed MULT/DIV engine with its own sequencer. Operands are
// converted to magnitudes on acceptance, iterated WIDTH times through
// md_step, then sign-corrected into hi/lo.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; aborts any operation silently
//   bus    : mult_div_seq_if slave (start/MDCtrl/a/b in, hi/lo/busy/done/div0 out)
// Timing: accept on edge N, iterate N+1..N+32, sign fix at N+33, done high
// for the following cycle. DIV by zero skips straight to DONE with div0.
// ----------------------------------------------------------------------------
module mult_div_seq
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_seq_if.slave bus
);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;

    // Magnitude of a signed operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_rem  (r_rem),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt),
        .o_rem  (w_rem_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= MD_MULT;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.MDCtrl;
                        r_sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_sign_r <= bus.a[WIDTH-1];
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_busy   <= 1'b1;
                        // MULT: multiplier shifts through the accumulator.
                        // DIV : dividend shifts out, quotient shifts in.
                        if (bus.MDCtrl == MD_MULT) begin
                            r_opnd <= mag(bus.a);
                            r_acc  <= {{WIDTH{1'b0}}, mag(bus.b)};
                        end else begin
                            r_opnd <= mag(bus.b);
                            r_acc  <= {{WIDTH{1'b0}}, mag(bus.a)};
                        end
                        if (bus.MDCtrl == MD_DIV && bus.b == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_div0  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_op == MD_MULT) begin
                        {r_hi, r_lo} <= cond_neg2(r_acc, r_sign_q);
                    end else begin
                        r_lo <= cond_neg(r_acc[WIDTH-1:0], r_sign_q);
                        r_hi <= cond_neg(r_rem, r_sign_r);
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.div0 = r_div0;

endmodule

// File: tb/tb_mult_div_seq.sv
// ----------------------------------------------------------------------------
// tb_mult_div_seq
// Directed vectors with hand-computed results for mult_div_seq: latency,
// busy/done/div0 timing, signed MULT/DIV results, divide-by-zero, ignored
// start requests and asynchronous reset mid-operation.
// ----------------------------------------------------------------------------
module tb_mult_div_seq;
    import md_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mult_div_seq_if #(.WIDTH(32)) bus ();

    mult_div_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Present a request for edge N; operands are scrambled right after the
    // edge so any late sampling shows up as a wrong result.
    task automatic start_op(input logic op, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.MDCtrl = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.MDCtrl = ~op;
        bus.a      = ~a;
        bus.b      = ~b;
    endtask

    // Count edges after acceptance until done is seen (bounded).
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            busy_ok = busy_ok & bus.busy;
            @(posedge clk);
            #1;
            lat++;
        end
        busy_ok = busy_ok & bus.busy;
    endtask

    task automatic run_check(input string tag, input logic op,
                             input logic [31:0] a, input logic [31:0] b,
                             input int exp_lat, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_div0);
        int   lat;
        logic bok;
        start_op(op, a, b);
        wait_done(lat, bok);
        check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, " busy held"}, 64'(bok), 64'(1));
        check_val({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check_val({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check_val({tag, " div0"}, 64'(bus.div0), 64'(exp_div0));
        @(posedge clk);
        #1;
        check_val({tag, " after done/busy/div0"},
                  64'({bus.done, bus.busy, bus.div0}), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic bok;
        logic seen_done;

        bus.start  = 1'b0;
        bus.MDCtrl = MD_MULT;
        bus.a      = '0;
        bus.b      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("reset hi/lo", {bus.hi, bus.lo}, 64'(0));
        check_val("reset busy/done/div0", 64'({bus.busy, bus.done, bus.div0}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle busy/done/div0", 64'({bus.busy, bus.done, bus.div0}), 64'(0));

        // Signed MULT / DIV vectors
        run_check("mul 7*-3",   MD_MULT, 32'd7,   32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_check("mul -5*-6",  MD_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 33, 32'h0, 32'd30, 1'b0);
        run_check("div 100/7",  MD_DIV,  32'd100, 32'd7,         33, 32'd2,        32'd14,        1'b0);
        run_check("div -7/2",   MD_DIV,  32'hFFFF_FFF9, 32'd2,   33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        // Divide by zero: immediate done, hi/lo keep the -7/2 result
        run_check("div 5/0",    MD_DIV,  32'd5,   32'd0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        run_check("div 7/-2",   MD_DIV,  32'd7,   32'hFFFF_FFFE, 33, 32'd1,        32'hFFFF_FFFD, 1'b0);
        run_check("mul min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 1'b0);
        run_check("div min/-1", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);

        // Second start while busy is ignored; first result keeps its schedule
        start_op(MD_MULT, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.MDCtrl = MD_DIV;
        bus.a      = 32'd100;
        bus.b      = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bok);
        check_val("ignored start latency", 64'(lat), 64'(23));
        check_val("ignored start busy held", 64'(bok), 64'(1));
        check_val("ignored start div0", 64'(bus.div0), 64'(0));
        check_val("ignored start hi", 64'(bus.hi), 64'(0));
        check_val("ignored start lo", 64'(bus.lo), 64'(42));
        // Start presented during DONE is dropped as well
        @(negedge clk);
        bus.start  = 1'b1;
        bus.MDCtrl = MD_DIV;
        bus.a      = 32'd1;
        bus.b      = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_val("start in DONE dropped", 64'({bus.busy, bus.done, bus.div0}), 64'(0));
        @(posedge clk);
        #1;
        check_val("start in DONE not queued", 64'({bus.busy, bus.done, bus.div0}), 64'(0));

        // Asynchronous reset in the middle of a DIV
        start_op(MD_DIV, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("async reset hi/lo", {bus.hi, bus.lo}, 64'(0));
        check_val("async reset busy/done/div0", 64'({bus.busy, bus.done, bus.div0}), 64'(0));
        @(negedge clk);
        reset     = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | bus.done | bus.busy;
        end
        check_val("aborted op silent", 64'(seen_done), 64'(0));
        run_check("mul 3*4 after reset", MD_MULT, 32'd3, 32'd4, 33, 32'h0, 32'd12, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
